mic_array_rx: RTL

MIC_ARRAY_RX -- requirements
Module: mic_array_rx

---
 rtl/mic_array_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mic_array_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mic_array_rx : multi-line I2S microphone receiver with frame commit      |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module mic_array_rx #(
  parameter int N_LINES = 3,
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mic_sck,
  input  logic                          mic_ws,
  input  logic [N_LINES-1:0]            mic_sd,
  input  logic [2*N_LINES-1:0]          chan_en,
  output logic [2*N_LINES*DATA_W-1:0]   mic_data,
  output logic                          rx_done_pedge,
  output logic                          frame_err,
  output logic [15:0]                   frame_cnt
);

  localparam int                CNT_W    = $clog2(SLOT_W + 2);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(SLOT_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_DATA = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // sck_q[1:0] is the synchronizer, sck_q[2] the previous synced value
  logic [2:0]                  sck_q;
  logic [1:0]                  ws_q;
  logic [N_LINES-1:0]          sd_s1_q, sd_s2_q;

  logic                        ws_last_q, ws_last_d;
  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
  logic [N_LINES*DATA_W-1:0]   shift_q, shift_d;
  logic [N_LINES*DATA_W-1:0]   shadow_q, shadow_d;
  logic                        shadow_pend_q, shadow_pend_d;
  logic                        commit_pend_q, commit_pend_d;
  logic [2*N_LINES*DATA_W-1:0] data_q, data_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [15:0]                 frame_cnt_q, frame_cnt_d;

  logic sck_rise;
  logic ws_edge;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ws_edge  = ws_q[1] ^ ws_last_q;

  always_comb begin
    ws_last_d     = ws_last_q;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    shadow_d      = shadow_q;
    shadow_pend_d = 1'b0;
    commit_pend_d = 1'b0;
    data_d        = data_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (sck_rise) begin
      ws_last_d = ws_q[1];
      if (ws_edge) begin
        bit_cnt_d = '0;
        // A full slot is SLOT_W rises: the edge rise itself plus SLOT_W-1 counted ones
        if (state_q != IDLE && bit_cnt_q != CNT_FULL) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!ws_q[1]) begin
          state_d = LEFT;
        end else if (state_q == LEFT) begin
          state_d = RIGHT;
        end
      end else begin
        if (bit_cnt_q != CNT_SAT) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (bit_cnt_q < CNT_DATA) begin
          for (int k = 0; k < N_LINES; k++) begin
            shift_d[k*DATA_W +: DATA_W] = {shift_q[k*DATA_W +: DATA_W-1], sd_s2_q[k]};
          end
        end
        if (bit_cnt_q == CNT_LAST) begin
          shadow_pend_d = (state_q == LEFT);
          commit_pend_d = (state_q == RIGHT);
        end
      end
    end

    if (shadow_pend_q) begin
      shadow_d = shift_q;
    end

    if (commit_pend_q) begin
      for (int k = 0; k < N_LINES; k++) begin
        data_d[(2*k)*DATA_W +: DATA_W]   = chan_en[2*k]   ? shadow_q[k*DATA_W +: DATA_W] : '0;
        data_d[(2*k+1)*DATA_W +: DATA_W] = chan_en[2*k+1] ? shift_q[k*DATA_W +: DATA_W]  : '0;
      end
      done_d      = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q         <= '0;
      ws_q          <= '0;
      sd_s1_q       <= '0;
      sd_s2_q       <= '0;
      ws_last_q     <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      shadow_q      <= '0;
      shadow_pend_q <= 1'b0;
      commit_pend_q <= 1'b0;
      data_q        <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      sck_q         <= {sck_q[1], sck_q[0], mic_sck};
      ws_q          <= {ws_q[0], mic_ws};
      sd_s1_q       <= mic_sd;
      sd_s2_q       <= sd_s1_q;
      ws_last_q     <= ws_last_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      shadow_q      <= shadow_d;
      shadow_pend_q <= shadow_pend_d;
      commit_pend_q <= commit_pend_d;
      data_q        <= data_d;
      done_q        <= done_d;
      err_q         <= err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign mic_data      = data_q;
  assign rx_done_pedge = done_q;
  assign frame_err     = err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
`default_nettype wire
